// File: rtl/lookup_table_param_if.sv
// Bus bundle for lookup_table_param: write port, read port, reload request
// and the registered read/status outputs.
interface lookup_table_param_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) ();
  logic              reload;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              busy;

  modport master (
    output reload, we, waddr, wdata, re, raddr,
    input  dout, dout_valid, busy
  );

  modport slave (
    input  reload, we, waddr, wdata, re, raddr,
    output dout, dout_valid, busy
  );
endinterface

// File: rtl/lookup_table_param.sv
// Parametrised rewritable lookup table with a registered read port,
// write-first same-address bypass and a hardware default-content loader.
module lookup_table_param #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  lookup_table_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic INIT  = 1'b0;
  localparam logic READY = 1'b1;

  logic              state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] idx_inv;
  logic              accept;

  // DEPTH-1-idx is the bitwise inverse of idx within ADDR_W bits.
  assign idx_inv = ~idx;
  assign accept  = (state == READY) && !bus.reload;

  // Single memory write port shared by the loader and the user write path.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = bus.waddr;
    mem_data = bus.wdata;
    if (state == INIT) begin
      mem_we   = 1'b1;
      mem_addr = idx;
      mem_data = DATA_W'(idx_inv);
    end else if (accept && bus.we) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= INIT;
      idx          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (state == INIT) begin
        // idx wraps back to zero on the final entry.
        idx <= idx + 1'b1;
        if (idx == '1) begin
          state <= READY;
        end
      end else if (bus.reload) begin
        state <= INIT;
        idx   <= '0;
      end else if (bus.re) begin
        dout_valid_q <= 1'b1;
        if (bus.we && (bus.waddr == bus.raddr)) begin
          dout_q <= bus.wdata;
        end else begin
          dout_q <= mem[bus.raddr];
        end
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = (state == INIT);
endmodule

// File: tb/tb_lookup_table_param.sv
// Directed self-checking bench for lookup_table_param: a 4x16 instance for
// the main access/reload/reset scenarios and a 3x16 instance for truncation.
module tb_lookup_table_param;
  logic clk = 1'b0;
  logic rst = 1'b1;

  int errors = 0;
  int checks = 0;

  lookup_table_param_if #(.DATA_W(4), .ADDR_W(4)) bus0 ();
  lookup_table_param_if #(.DATA_W(3), .ADDR_W(4)) bus1 ();

  lookup_table_param #(.DATA_W(4), .ADDR_W(4)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  lookup_table_param #(.DATA_W(3), .ADDR_W(4)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] waddr;
    logic [3:0] wdata;
    logic       re;
    logic [3:0] raddr;
    logic [3:0] exp_dout;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts edges until busy drops on both instances, bounded at 40.
  task automatic wait_ready(output int n0, output int n1);
    bit d0 = 1'b0;
    bit d1 = 1'b0;
    n0 = 0;
    n1 = 0;
    for (int k = 1; k <= 40 && !(d0 && d1); k++) begin
      tick();
      if (!d0 && !bus0.busy) begin n0 = k; d0 = 1'b1; end
      if (!d1 && !bus1.busy) begin n1 = k; d1 = 1'b1; end
    end
  endtask

  task automatic idle_inputs();
    bus0.reload = 1'b0; bus0.we = 1'b0; bus0.waddr = '0; bus0.wdata = '0;
    bus0.re = 1'b0; bus0.raddr = '0;
    bus1.reload = 1'b0; bus1.we = 1'b0; bus1.waddr = '0; bus1.wdata = '0;
    bus1.re = 1'b0; bus1.raddr = '0;
  endtask

  initial begin
    int n0;
    int n1;

    //            we  waddr wdata re  raddr dout  valid
    vecs[0]  = '{1'b0, 4'd0, 4'h0, 1'b1, 4'd0,  4'd15, 1'b1};
    vecs[1]  = '{1'b0, 4'd0, 4'h0, 1'b1, 4'd5,  4'd10, 1'b1};
    vecs[2]  = '{1'b0, 4'd0, 4'h0, 1'b1, 4'd15, 4'd0,  1'b1};
    vecs[3]  = '{1'b0, 4'd0, 4'h0, 1'b0, 4'd0,  4'd0,  1'b0};
    vecs[4]  = '{1'b1, 4'd3, 4'hA, 1'b1, 4'd3,  4'hA,  1'b1};
    vecs[5]  = '{1'b0, 4'd0, 4'h0, 1'b1, 4'd3,  4'hA,  1'b1};
    vecs[6]  = '{1'b1, 4'd2, 4'h7, 1'b1, 4'd9,  4'd6,  1'b1};
    vecs[7]  = '{1'b0, 4'd0, 4'h0, 1'b1, 4'd2,  4'h7,  1'b1};
    vecs[8]  = '{1'b1, 4'd4, 4'h1, 1'b0, 4'd0,  4'h7,  1'b0};
    vecs[9]  = '{1'b0, 4'd0, 4'h0, 1'b1, 4'd4,  4'h1,  1'b1};
    vecs[10] = '{1'b1, 4'd15, 4'h3, 1'b1, 4'd0, 4'd15, 1'b1};
    vecs[11] = '{1'b0, 4'd0, 4'h0, 1'b1, 4'd15, 4'h3,  1'b1};

    idle_inputs();
    tick();
    tick();
    chk("rst dout0", int'(bus0.dout), 0);
    chk("rst valid0", int'(bus0.dout_valid), 0);
    chk("rst busy0", int'(bus0.busy), 1);
    chk("rst busy1", int'(bus1.busy), 1);
    rst = 1'b0;

    wait_ready(n0, n1);
    chk("init edges0", n0, 16);
    chk("init edges1", n1, 16);

    for (int i = 0; i < 12; i++) begin
      bus0.we    = vecs[i].we;
      bus0.waddr = vecs[i].waddr;
      bus0.wdata = vecs[i].wdata;
      bus0.re    = vecs[i].re;
      bus0.raddr = vecs[i].raddr;
      tick();
      chk($sformatf("vec%0d dout", i), int'(bus0.dout), int'(vecs[i].exp_dout));
      chk($sformatf("vec%0d valid", i), int'(bus0.dout_valid), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d busy", i), int'(bus0.busy), 0);
    end

    // Reload with concurrent write/read that must be ignored throughout.
    bus0.reload = 1'b1;
    bus0.we = 1'b1; bus0.waddr = 4'd4; bus0.wdata = 4'hF;
    bus0.re = 1'b1; bus0.raddr = 4'd4;
    tick();
    chk("reload busy", int'(bus0.busy), 1);
    chk("reload valid", int'(bus0.dout_valid), 0);
    chk("reload dout", int'(bus0.dout), 3);
    bus0.reload = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("load%0d busy", i), int'(bus0.busy), (i < 16) ? 1 : 0);
      chk($sformatf("load%0d valid", i), int'(bus0.dout_valid), 0);
      chk($sformatf("load%0d dout", i), int'(bus0.dout), 3);
    end
    bus0.we = 1'b0;
    bus0.raddr = 4'd4;
    tick();
    chk("post reload rd4 dout", int'(bus0.dout), 11);
    chk("post reload rd4 valid", int'(bus0.dout_valid), 1);
    bus0.raddr = 4'd15;
    tick();
    chk("post reload rd15 dout", int'(bus0.dout), 0);
    bus0.re = 1'b0;

    // reload held high: one READY cycle between back-to-back loads.
    bus0.reload = 1'b1;
    tick();
    chk("held busy N", int'(bus0.busy), 1);
    for (int i = 0; i < 15; i++) tick();
    chk("held busy N+15", int'(bus0.busy), 1);
    tick();
    chk("held busy N+16", int'(bus0.busy), 0);
    tick();
    chk("held busy N+17", int'(bus0.busy), 1);
    bus0.reload = 1'b0;

    // Advance the loader to idx=7, then reset asynchronously mid-cycle.
    for (int i = 0; i < 7; i++) tick();
    chk("pre rst dout", int'(bus0.dout), 0);
    bus0.we = 1'b1; bus0.waddr = 4'd1; bus0.wdata = 4'h5;
    #2;
    rst = 1'b1;
    #1;
    chk("async rst dout0", int'(bus0.dout), 0);
    chk("async rst valid0", int'(bus0.dout_valid), 0);
    chk("async rst busy0", int'(bus0.busy), 1);
    chk("async rst busy1", int'(bus1.busy), 1);
    rst = 1'b0;
    bus0.we = 1'b0;
    wait_ready(n0, n1);
    chk("reinit edges0", n0, 16);
    chk("reinit edges1", n1, 16);

    // Full-table back-to-back reads on both widths.
    bus0.re = 1'b1;
    bus1.re = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus0.raddr = 4'(i);
      bus1.raddr = 4'(i);
      tick();
      chk($sformatf("b2b0 a%0d dout", i), int'(bus0.dout), 15 - i);
      chk($sformatf("b2b0 a%0d valid", i), int'(bus0.dout_valid), 1);
      chk($sformatf("b2b1 a%0d dout", i), int'(bus1.dout), (15 - i) & 7);
      chk($sformatf("b2b1 a%0d valid", i), int'(bus1.dout_valid), 1);
    end
    bus0.re = 1'b0;
    bus1.re = 1'b0;
    tick();
    chk("idle valid0", int'(bus0.dout_valid), 0);
    chk("idle dout0", int'(bus0.dout), 0);
    chk("idle valid1", int'(bus1.dout_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
